// File: rtl/divide_unit_pkg.sv
// Shared types and sizing for the iterative restoring divider.
package divide_unit_pkg;

    localparam int unsigned WORD_LENGTH = 32;
    localparam int unsigned DIV_CNT_W   = $clog2(WORD_LENGTH);

    typedef enum logic [2:0] {
        DIV_ST_IDLE = 3'd0,
        DIV_ST_PREP = 3'd1,
        DIV_ST_ITER = 3'd2,
        DIV_ST_FIX  = 3'd3,
        DIV_ST_DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/divide_unit_adder.sv
// Ripple-style adder with carry in/out, used for the trial subtraction.
module divide_unit_adder #(
    parameter int unsigned WIDTH = 33
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_c,
    output logic             cout_c
);
    localparam int unsigned SUM_W = WIDTH + 1;

    always_comb begin
        {cout_c, sum_c} = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
    end

endmodule

// File: rtl/divide_unit.sv
// Radix-2 restoring divider: signed/unsigned quotient and remainder, one bit per cycle.
module divide_unit
    import divide_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_LENGTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] q,
    output logic [0:WIDTH-1] r,
    output logic             err
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned EXT_W = WIDTH + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] op_a, op_a_nxt, op_b, op_b_nxt;
    logic             op_sgn, op_sgn_nxt;
    logic [WIDTH-1:0] dvd, dvd_nxt, dvs, dvs_nxt;
    logic [EXT_W-1:0] rem, rem_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             q_neg, q_neg_nxt, r_neg, r_neg_nxt;
    logic [WIDTH-1:0] q_nxt, r_nxt;
    logic             err_nxt, busy_nxt, done_nxt;

    logic             div_zero_c, ovf_c, last_c, a_neg_c, b_neg_c;
    logic [EXT_W-1:0] rem_sh_c, diff_c;
    logic             no_borrow_c;

    assign div_zero_c = (op_b == '0);
    assign ovf_c      = op_sgn && (op_a == MIN_NEG) && (&op_b);
    assign last_c     = (cnt == CNT_W'(WIDTH - 1));
    assign a_neg_c    = op_sgn && op_a[WIDTH-1];
    assign b_neg_c    = op_sgn && op_b[WIDTH-1];
    assign rem_sh_c   = (rem << 1) | EXT_W'(dvd[WIDTH-1]);

    // Trial subtraction: rem_sh - |b| as rem_sh + ~|b| + 1; carry out means no borrow.
    divide_unit_adder #(.WIDTH(EXT_W)) u_trial_sub (
        .a      (rem_sh_c),
        .b      (~{1'b0, dvs}),
        .cin    (1'b1),
        .sum_c  (diff_c),
        .cout_c (no_borrow_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DIV_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_ST_IDLE: if (start) state_nxt = DIV_ST_PREP;
            DIV_ST_PREP: state_nxt = (div_zero_c || ovf_c) ? DIV_ST_DONE : DIV_ST_ITER;
            DIV_ST_ITER: if (last_c) state_nxt = DIV_ST_FIX;
            DIV_ST_FIX:  state_nxt = DIV_ST_DONE;
            DIV_ST_DONE: state_nxt = start ? DIV_ST_PREP : DIV_ST_IDLE;
            default:     state_nxt = DIV_ST_IDLE;
        endcase
    end

    always_comb begin
        op_a_nxt   = op_a;
        op_b_nxt   = op_b;
        op_sgn_nxt = op_sgn;
        dvd_nxt    = dvd;
        dvs_nxt    = dvs;
        rem_nxt    = rem;
        cnt_nxt    = cnt;
        q_neg_nxt  = q_neg;
        r_neg_nxt  = r_neg;
        q_nxt      = q;
        r_nxt      = r;
        err_nxt    = err;
        busy_nxt   = (state_nxt == DIV_ST_PREP) || (state_nxt == DIV_ST_ITER) ||
                     (state_nxt == DIV_ST_FIX);
        done_nxt   = (state_nxt == DIV_ST_DONE);
        unique case (state)
            DIV_ST_IDLE, DIV_ST_DONE: begin
                if (start) begin
                    op_a_nxt   = a;
                    op_b_nxt   = b;
                    op_sgn_nxt = sgn;
                end
            end
            DIV_ST_PREP: begin
                if (div_zero_c) begin
                    q_nxt   = '1;
                    r_nxt   = op_a;
                    err_nxt = 1'b1;
                end else if (ovf_c) begin
                    q_nxt   = MIN_NEG;
                    r_nxt   = '0;
                    err_nxt = 1'b1;
                end else begin
                    dvd_nxt   = a_neg_c ? (~op_a + WIDTH'(1)) : op_a;
                    dvs_nxt   = b_neg_c ? (~op_b + WIDTH'(1)) : op_b;
                    q_neg_nxt = a_neg_c ^ b_neg_c;
                    r_neg_nxt = a_neg_c;
                    rem_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            DIV_ST_ITER: begin
                rem_nxt = no_borrow_c ? diff_c : rem_sh_c;
                dvd_nxt = (dvd << 1) | WIDTH'(no_borrow_c);
                cnt_nxt = cnt + CNT_W'(1);
            end
            DIV_ST_FIX: begin
                q_nxt   = q_neg ? (~dvd + WIDTH'(1)) : dvd;
                r_nxt   = r_neg ? (~rem[WIDTH-1:0] + WIDTH'(1)) : rem[WIDTH-1:0];
                err_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sgn <= 1'b0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            q      <= '0;
            r      <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            op_a   <= op_a_nxt;
            op_b   <= op_b_nxt;
            op_sgn <= op_sgn_nxt;
            dvd    <= dvd_nxt;
            dvs    <= dvs_nxt;
            rem    <= rem_nxt;
            cnt    <= cnt_nxt;
            q_neg  <= q_neg_nxt;
            r_neg  <= r_neg_nxt;
            q      <= q_nxt;
            r      <= r_nxt;
            err    <= err_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_divide_unit.sv
// Scoreboard bench for divide_unit: directed operands, per-cycle checks of busy/done/q/r/err.
module tb_divide_unit;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        err;
        int          t0;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [0:31] a;
    logic [0:31] b;
    logic        busy;
    logic        done;
    logic [0:31] q;
    logic [0:31] r;
    logic        err;

    int          cyc;
    int          n_cmp;
    int          n_err;
    exp_t        sb[$];
    logic [31:0] hold_q;
    logic [31:0] hold_r;
    logic        hold_err;

    divide_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge, pop on expected done.
    initial begin
        logic exp_busy;
        logic exp_done;
        exp_t e;
        hold_q   = '0;
        hold_r   = '0;
        hold_err = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                sb.delete();
                hold_q   = '0;
                hold_r   = '0;
                hold_err = 1'b0;
            end
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (sb.size() > 0) begin
                exp_busy = (cyc > sb[0].t0) && (cyc < sb[0].t0 + sb[0].lat);
                exp_done = (cyc == sb[0].t0 + sb[0].lat);
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                e        = sb.pop_front();
                hold_q   = e.q;
                hold_r   = e.r;
                hold_err = e.err;
            end
            chk("q", q, hold_q);
            chk("r", r, hold_r);
            chk("err", 32'(err), 32'(hold_err));
        end
    end

    // Caller must be at a falling edge; start is accepted at the next rising edge.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         input logic [31:0] eq, input logic [31:0] er, input logic ee,
                         input int lat, output int t0);
        exp_t e;
        a     = ia;
        b     = ib;
        sgn   = is;
        start = 1'b1;
        t0    = cyc;
        e     = '{q: eq, r: er, err: ee, t0: cyc, lat: lat};
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                       input logic [31:0] eq, input logic [31:0] er, input logic ee,
                       input int lat);
        int t0;
        issue(ia, ib, is, eq, er, ee, lat, t0);
        drain();
    endtask

    initial begin
        int t0;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(32'd100,      32'd7,      1'b0, 32'd14,       32'd2,        1'b0, 35);
        run(32'hFFFFFF9C, 32'd7,      1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 35);
        run(32'd5,        32'd0,      1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 2);
        run(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,      1'b1, 2);
        run(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,      32'h80000000, 1'b0, 35);
        run(32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,      1'b0, 35);
        run(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3,      32'hFFFFFFFF, 1'b0, 35);
        run(32'h80000000, 32'd1,      1'b1, 32'h80000000, 32'd0,        1'b0, 35);
        run(32'd0,        32'd5,      1'b1, 32'd0,        32'd0,        1'b0, 35);

        // Reset at cycle 10 aborts the operation and clears held results.
        issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 35, t0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 35);

        // start held high while busy must be ignored.
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 35, t0);
        repeat (4) @(negedge clk);
        a     = 32'd3;
        b     = 32'd1;
        start = 1'b1;
        repeat (16) @(negedge clk);
        start = 1'b0;
        drain();

        // Back-to-back: second start issued in the DONE cycle.
        issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 35, t0);
        while (cyc < t0 + 35) @(negedge clk);
        issue(32'hFFFFFFFF, 32'd16, 1'b0, 32'h0FFFFFFF, 32'd15, 1'b0, 35, t0);
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
